// File: rtl/crc32_ci_if.sv
// Custom-instruction port bundle for crc32_ci: clock enable, start strobe,
// opcode and operand towards the unit; completion pulse and result back.
interface crc32_ci_if;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    modport master (
        output clk_en,
        output start,
        output n,
        output dataa,
        input  done,
        input  result
    );

    modport slave (
        input  clk_en,
        input  start,
        input  n,
        input  dataa,
        output done,
        output result
    );
endinterface

// File: rtl/crc32_ci.sv
// Multi-cycle Nios II custom instruction: reflected CRC-32, one byte folded per cycle.
// Define CRC32_CI_BIG_ENDIAN_EN to fold WORD operands MSB-first (shift register shifts left).
module crc32_ci #(
    parameter logic [31:0] POLY = 32'hEDB88320,
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic       clk,
    input  logic       reset_n,
    crc32_ci_if.slave  ci
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT = 2'd0,
        OP_WORD = 2'd1,
        OP_READ = 2'd2,
        OP_BYTE = 2'd3
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

`ifdef CRC32_CI_BIG_ENDIAN_EN
    function automatic logic [7:0] lead_byte(input logic [31:0] w);
        return w[31:24];
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] w);
        return w << 8;
    endfunction
`else
    function automatic logic [7:0] lead_byte(input logic [31:0] w);
        return w[7:0];
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] w);
        return w >> 8;
    endfunction
`endif

    // Single-cycle ops execute in the accept cycle and go straight to DONE,
    // which gives done in C1; WORD spends C1..C3 in EXEC folding bytes 1..3.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        result_d = result_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        case (state_q)
            IDLE: begin
                if (ci.start) begin
                    case (op_t'(ci.n))
                        OP_INIT: begin
                            crc_d    = SEED;
                            result_d = '0;
                            state_d  = DONE;
                            done_d   = 1'b1;
                        end
                        OP_WORD: begin
                            crc_d   = crc_byte(crc_q, lead_byte(ci.dataa));
                            shreg_d = shift_out(ci.dataa);
                            cnt_d   = 2'd1;
                            state_d = EXEC;
                        end
                        OP_READ: begin
                            result_d = ~crc_q;
                            state_d  = DONE;
                            done_d   = 1'b1;
                        end
                        OP_BYTE: begin
                            crc_d    = crc_byte(crc_q, ci.dataa[7:0]);
                            result_d = ~crc_d;
                            state_d  = DONE;
                            done_d   = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            EXEC: begin
                crc_d   = crc_byte(crc_q, lead_byte(shreg_q));
                shreg_d = shift_out(shreg_q);
                if (cnt_q == 2'd3) begin
                    cnt_d    = '0;
                    result_d = ~crc_d;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clk_en low freezes everything, including a pending done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            crc_q    <= SEED;
            result_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
        end else if (ci.clk_en) begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            result_q <= result_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
        end
    end

    assign ci.done   = done_q;
    assign ci.result = result_q;

endmodule

// File: tb/tb_crc32_ci.sv
// Scoreboard bench for crc32_ci: driver pushes expected result and done cycle,
// monitor pops and compares on every done; reference is a bit-serial CRC over the message.
module tb_crc32_ci;

    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;
`ifdef CRC32_CI_BIG_ENDIAN_EN
    localparam logic [31:0] W1 = 32'h31323334;
    localparam logic [31:0] W2 = 32'h35363738;
`else
    localparam logic [31:0] W1 = 32'h34333231;
    localparam logic [31:0] W2 = 32'h38373635;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    crc32_ci_if ci();

    crc32_ci #(.POLY(POLY), .SEED(SEED)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ci      (ci)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned at;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  msg[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h required %08h", tag, act, req);
        end
    endtask

    // CRC of the whole message since the last INIT, one bit at a time.
    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        c = SEED;
        foreach (msg[k]) begin
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ msg[k][i]) c = (c >> 1) ^ POLY;
                else                  c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic void push_word(input logic [31:0] w);
`ifdef CRC32_CI_BIG_ENDIAN_EN
        for (int b = 3; b >= 0; b--) msg.push_back(8'((w >> (8 * b)) & 32'hFF));
`else
        for (int b = 0; b < 4; b++) msg.push_back(8'((w >> (8 * b)) & 32'hFF));
`endif
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && ci.done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d required none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_result"}, ci.result, e.res);
                    check({e.tag, "_cycle"}, cyc, e.at);
                end
            end
        end
    end

    // Called just after a negedge in the cycle that becomes C0; returns in the
    // IDLE cycle after done. stall: clk_en low for that many cycles after C1.
    // ign_at: cycle index carrying an extra start that must be ignored.
    task automatic issue(input logic [1:0] op, input logic [31:0] data,
                         input int unsigned stall, input int unsigned ign_at,
                         input bit has_k, input logic [31:0] k, input string tag);
        exp_t        e;
        int unsigned lat;
        case (op)
            2'd0: msg.delete();
            2'd1: push_word(data);
            2'd3: msg.push_back(data[7:0]);
            default: ;
        endcase
        e.res = (op == 2'd0) ? 32'h0 : ref_crc();
        if (has_k) e.res = k;
        lat   = (op == 2'd1) ? 4 + stall : 1;
        e.at  = cyc + lat;
        e.tag = tag;
        sb.push_back(e);
        ci.start  = 1'b1;
        ci.n      = op;
        ci.dataa  = data;
        ci.clk_en = 1'b1;
        for (int unsigned c = 1; c <= lat; c++) begin
            @(negedge clk);
            ci.start  = (c == ign_at);
            ci.n      = 2'($urandom_range(0, 3));
            ci.dataa  = $urandom;
            ci.clk_en = !(op == 2'd1 && c >= 2 && c < 2 + stall);
        end
        @(negedge clk);
        ci.start  = 1'b0;
        ci.clk_en = 1'b1;
    endtask

    task automatic reset_mid_word(input logic [31:0] data);
        ci.start  = 1'b1;
        ci.n      = 2'd1;
        ci.dataa  = data;
        ci.clk_en = 1'b1;
        @(negedge clk);
        ci.start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_done", {31'd0, ci.done}, 32'h0);
        check("rst_mid_result", ci.result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        msg.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  op;
        int unsigned st, ig;
        ci.clk_en = 1'b1;
        ci.start  = 1'b0;
        ci.n      = 2'd0;
        ci.dataa  = '0;
        repeat (2) @(negedge clk);
        check("reset_done", {31'd0, ci.done}, 32'h0);
        check("reset_result", ci.result, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(2'd0, 32'h0, 0, 0, 1'b1, 32'h0, "chk_init");
        issue(2'd1, W1, 0, 0, 1'b0, 32'h0, "chk_w1");
        issue(2'd1, W2, 0, 0, 1'b0, 32'h0, "chk_w2");
        issue(2'd3, 32'h39, 0, 0, 1'b0, 32'h0, "chk_byte");
        issue(2'd2, 32'h0, 0, 0, 1'b1, 32'hCBF43926, "chk_read");

        issue(2'd0, 32'h0, 0, 0, 1'b1, 32'h0, "one_init");
        issue(2'd3, 32'h0, 0, 0, 1'b1, 32'hD202EF8D, "one_byte");
        issue(2'd2, 32'h0, 0, 0, 1'b1, 32'hD202EF8D, "one_read");

        issue(2'd0, 32'h0, 0, 0, 1'b1, 32'h0, "stall_init");
        issue(2'd1, W1, 3, 0, 1'b0, 32'h0, "stall_w1");
        issue(2'd1, W2, 0, 0, 1'b0, 32'h0, "stall_w2");
        issue(2'd3, 32'h39, 0, 0, 1'b0, 32'h0, "stall_byte");
        issue(2'd2, 32'h0, 0, 0, 1'b1, 32'hCBF43926, "stall_read");

        issue(2'd0, 32'h0, 0, 0, 1'b1, 32'h0, "ign_init");
        issue(2'd1, W1, 0, 2, 1'b0, 32'h0, "ign_w1");
        issue(2'd1, W2, 0, 0, 1'b0, 32'h0, "ign_w2");
        issue(2'd3, 32'h39, 0, 0, 1'b0, 32'h0, "ign_byte");
        issue(2'd2, 32'h0, 0, 0, 1'b1, 32'hCBF43926, "ign_read");

        reset_mid_word($urandom);
        issue(2'd2, 32'h0, 0, 0, 1'b1, 32'h0, "rst_read");

        for (int unsigned t = 0; t < 300; t++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0 && $urandom_range(0, 2) != 0) op = 2'd1;
            st = (op == 2'd1) ? $urandom_range(0, 3) : 0;
            ig = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (op == 2'd1) ? 4 + st : 1) : 0;
            issue(op, $urandom, st, ig, 1'b0, 32'h0, "rand");
        end

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: got %0d outstanding required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
